// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, the op bus width and the FSM state encoding.
package mul_div_unit_pkg;

  localparam int MDU_OP_BUS = 2;

  typedef enum logic [MDU_OP_BUS-1:0] {
    MDU_OP_MULT  = 2'b00,
    MDU_OP_MULTU = 2'b01,
    MDU_OP_DIV   = 2'b10,
    MDU_OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  // Divide operations share op[1] = 1.
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // Signed operations share op[0] = 0.
  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result channel between the EX stage and the multiply/divide unit.
// The result side drives the HI/LO register file write port directly.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [MDU_OP_BUS-1:0] op;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  cancel;
  logic                  busy;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] hi_o;
  logic [DATA_WIDTH-1:0] lo_o;

  modport master (
    output start, op, operand_a, operand_b, cancel,
    input  busy, write_en, hi_o, lo_o
  );

  modport slave (
    input  start, op, operand_a, operand_b, cancel,
    output busy, write_en, hi_o, lo_o
  );
endinterface

// File: rtl/mdu_sign_fix.sv
// Sign correction applied to the raw unsigned result. Multiplies negate the
// whole 64-bit product; divides negate quotient and remainder independently.
module mdu_sign_fix #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] val_i,
  input  logic                    neg_full_i,
  input  logic                    neg_hi_i,
  input  logic                    neg_lo_i,
  output logic [2*DATA_WIDTH-1:0] val_o
);
  logic [DATA_WIDTH-1:0] hi_in, lo_in, hi_fix, lo_fix;

  // Conditional two's-complement negate of the full value or of each half.
  always_comb begin
    hi_in  = val_i[2*DATA_WIDTH-1:DATA_WIDTH];
    lo_in  = val_i[DATA_WIDTH-1:0];
    hi_fix = neg_hi_i ? (~hi_in + 1'b1) : hi_in;
    lo_fix = neg_lo_i ? (~lo_in + 1'b1) : lo_in;
    if (neg_full_i) begin
      val_o = ~val_i + 1'b1;
    end else begin
      val_o = {hi_fix, lo_fix};
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit (MULT, MULTU, DIV, DIVU) on
// magnitudes, with a final sign-correction cycle and a one-cycle HI/LO
// write strobe.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);
  localparam int W = DATA_WIDTH;

  mdu_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;

  // Operation context: not reset, only meaningful while busy.
  mdu_op_e              op_q, op_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0]         opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*W-1:0]       acc_q, acc_d;     // {acc_hi/rem, multiplier/quotient}

  mdu_op_e              op_in;
  logic                 a_neg, b_neg;
  logic [W-1:0]         a_mag, b_mag;
  logic [W:0]           mul_sum;
  logic [2*W-1:0]       mul_acc, div_acc, fixed;
  logic [W:0]           rem_sh;
  logic                 div_ge;
  logic [W-1:0]         rem_new;

  // Issue-side decode: sign flags and operand magnitudes.
  always_comb begin
    op_in = mdu_op_e'(bus.op);
    a_neg = op_is_signed(op_in) & bus.operand_a[W-1];
    b_neg = op_is_signed(op_in) & bus.operand_b[W-1];
    a_mag = a_neg ? (~bus.operand_a + 1'b1) : bus.operand_a;
    b_mag = b_neg ? (~bus.operand_b + 1'b1) : bus.operand_b;
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc = {mul_sum, acc_q[W-1:1]};
    rem_sh  = acc_q[2*W-1:W-1];
    div_ge  = (rem_sh >= {1'b0, opnd_q});
    rem_new = div_ge ? (rem_sh[W-1:0] - opnd_q) : rem_sh[W-1:0];
    div_acc = {rem_new, acc_q[W-2:0], div_ge};
  end

  mdu_sign_fix #(.DATA_WIDTH(W)) u_sign_fix (
    .val_i      (acc_q),
    .neg_full_i (~op_is_div(op_q) & (sa_q ^ sb_q)),
    .neg_hi_i   (op_is_div(op_q) & sa_q),
    .neg_lo_i   (op_is_div(op_q) & (sa_q ^ sb_q)),
    .val_o      (fixed)
  );

  // FSM next state, iteration datapath and result load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.cancel) begin
          op_d  = op_in;
          sa_d  = a_neg;
          sb_d  = b_neg;
          cnt_d = '0;
          // The low accumulator half carries the operand that gets shifted
          // out (multiplier) or in (dividend becoming quotient).
          if (op_is_div(op_in)) begin
            opnd_d = b_mag;
            acc_d  = {{W{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{W{1'b0}}, b_mag};
          end
          if (op_is_div(op_in) && (bus.operand_b == '0)) begin
            hi_d    = bus.operand_a;
            lo_d    = '1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = op_is_div(op_q) ? div_acc : mul_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_WIDTH'(W - 1)) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (bus.cancel) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          hi_d    = fixed[2*W-1:W];
          lo_d    = fixed[W-1:0];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The write strobe is already out this cycle; cancel cannot undo it.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state and architecturally visible results, with reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operation context registers, reloaded on every accepted start.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    sa_q   <= sa_d;
    sb_q   <= sb_d;
    opnd_q <= opnd_d;
    acc_q  <= acc_d;
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.write_en = (state_q == ST_DONE);
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, cancel/reset/ignored-start
// sequences, and random operations against an arithmetic reference model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mul_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mul_div_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign, as the unit must.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint      sp, sq, sr;
    logic [63:0] up;
    lat = 34;
    if (o[1] && b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      case (o)
        2'b00: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          hi = sp[63:32]; lo = sp[31:0];
        end
        2'b01: begin
          up = {32'd0, a} * {32'd0, b};
          hi = up[63:32]; lo = up[31:0];
        end
        2'b10: begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          hi = sr[31:0]; lo = sq[31:0];
        end
        default: begin
          hi = a % b; lo = a / b;
        end
      endcase
    end
  endtask

  // Issue one op and observe a fixed 60-cycle window. glitch_at>0 pulses a
  // second start (a DIVU by zero) during that cycle of the window.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int glitch_at,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int nwe, output logic busy1);
    int n;
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1; lat = -1; nwe = 0; hi = 'x; lo = 'x;
    busy1 = bus.busy;
    while (n < 60) begin
      if (bus.write_en) begin
        nwe++;
        if (lat < 0) begin
          lat = n; hi = bus.hi_o; lo = bus.lo_o;
        end
      end
      if (n == glitch_at) begin
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd9; bus.operand_b = 32'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int elat, input int glitch_at);
    logic [31:0] hi, lo;
    int          lat, nwe;
    logic        busy1;
    run_op(o, a, b, glitch_at, hi, lo, lat, nwe, busy1);
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, ehi});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, elo});
    chk({tag, " write_en count"}, 64'(nwe), 64'd1);
    chk({tag, " busy after start"}, {63'd0, busy1}, 64'd1);
    chk({tag, " hold hi/lo, idle"}, {bus.hi_o, bus.lo_o}, {ehi, elo});
    chk({tag, " busy low after"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] mhi, mlo, prev_hi, prev_lo;
    int          mlat, n, nwe;
    logic [1:0]  o;
    logic [31:0] a, b;

    tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34};
    tbl[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    tbl[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        34};
    tbl[4]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    tbl[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
    tbl[6]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    tbl[7]  = '{2'b10, 32'd0,         32'd0,         32'd0,         32'hFFFF_FFFF, 1};
    tbl[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         34};
    tbl[9]  = '{2'b01, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         34};
    tbl[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 34};
    tbl[11] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};

    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 2'b00;
    bus.operand_a = '0; bus.operand_b = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, bus.busy}, 64'd0);
    chk("reset write_en", {63'd0, bus.write_en}, 64'd0);
    chk("reset hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
               tbl[i].hi, tbl[i].lo, tbl[i].lat, 0);
    end
    prev_hi = tbl[11].hi; prev_lo = tbl[11].lo;

    // Cancel mid-MULT: busy drops, nothing written, results held.
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'd3; bus.operand_b = 32'd4;
    @(posedge clk); #1;
    bus.start = 1'b0; n = 1; nwe = 0;
    while (n < 10) begin
      @(posedge clk); #1; n++;
      if (bus.write_en) nwe++;
    end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    if (bus.write_en) nwe++;
    chk("cancel busy drop", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    if (bus.write_en) nwe++;
    chk("cancel no write_en", 64'(nwe), 64'd0);
    chk("cancel hold hi/lo", {bus.hi_o, bus.lo_o}, {prev_hi, prev_lo});
    check_op("after cancel", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 34, 0);

    // Start together with cancel in IDLE is not accepted.
    bus.start = 1'b1; bus.cancel = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd1; bus.operand_b = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("start+cancel busy", {64'(bus.busy), 64'(bus.write_en)} == 128'd0 ? 64'd0 : 64'd1, 64'd0);

    // Reset in the middle of a DIVU discards it.
    bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0; n = 1;
    while (n < 20) begin
      @(posedge clk); #1; n++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midop reset busy", {63'd0, bus.busy}, 64'd0);
    chk("midop reset write_en", {63'd0, bus.write_en}, 64'd0);
    chk("midop reset hi/lo", {bus.hi_o, bus.lo_o}, 64'd0);
    nwe = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.write_en) nwe++;
    end
    chk("midop reset no write_en", 64'(nwe), 64'd0);

    // Start while busy is ignored.
    check_op("start while busy", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 34, 5);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      model(o, a, b, mhi, mlo, mlat);
      check_op($sformatf("rand%0d op%0d %h/%h", i, o, a, b), o, a, b, mhi, mlo, mlat, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
